// File: rtl/melody_pkg.sv
// Shared widths, FSM encoding and the fixed melody table for the musicbox sequencer.
// The table lives in a function so elaboration can unroll it into per-step constants.
package melody_pkg;

  localparam int NOTE_W  = 4;
  localparam int DUR_W   = 3;
  localparam int SEQ_LEN = 8;
  localparam int STEP_W  = $clog2(SEQ_LEN);
  localparam int DCNT_W  = 27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } entry_t;

  // dur == 0 marks the end of the melody; note 0 with a nonzero dur is a timed rest.
  function automatic entry_t melody_entry(input logic [STEP_W-1:0] idx);
    entry_t e;
    case (idx)
      3'd0:    e = '{note: 4'd1, dur: 3'd2};
      3'd1:    e = '{note: 4'd9, dur: 3'd2};
      3'd2:    e = '{note: 4'd7, dur: 3'd4};
      default: e = '{note: 4'd0, dur: 3'd0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/melody_sequencer_btn_debounce.sv
// Two-flop synchronizer plus stability counter for one active-low pushbutton.
// Emits a single-cycle press pulse when the debounced level falls to pressed.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             press_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      press_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= btn_n;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      // Any sample agreeing with the current level restarts the stability window.
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        level_reg <= sync2_reg;
        press_reg <= ~sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the melody table on debounced play/stop presses, holding each note
// for dur beats followed by a silent gap; all outputs come straight from registers.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BEAT_CYCLES     = 12_500_000,
  parameter int GAP_CYCLES      = 1_250_000,
  parameter int LOOP            = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_play_n,
  input  logic              btn_stop_n,
  output logic [NOTE_W-1:0] note_code,
  output logic              busy,
  output logic [STEP_W-1:0] step_idx,
  output logic              done
);

  localparam logic [DCNT_W-1:0] GAP_LAST = DCNT_W'(GAP_CYCLES - 1);

  logic play_evt;
  logic stop_evt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_play (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_play_n),
    .press (play_evt)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_stop_n),
    .press (stop_evt)
  );

  // Per-step constants: sounding note, last count of the note phase, end marker.
  logic [NOTE_W-1:0] note_tab  [SEQ_LEN];
  logic [DCNT_W-1:0] play_last [SEQ_LEN];
  logic              end_tab   [SEQ_LEN];

  for (genvar gi = 0; gi < SEQ_LEN; gi++) begin : g_tab
    localparam entry_t ENTRY = melody_entry(STEP_W'(gi));
    assign note_tab[gi]  = ENTRY.note;
    assign end_tab[gi]   = (ENTRY.dur == '0);
    assign play_last[gi] = DCNT_W'(int'(ENTRY.dur) * BEAT_CYCLES - 1);
  end

  state_t            state_reg, state_next;
  logic [STEP_W-1:0] step_reg, step_next, step_inc;
  logic [DCNT_W-1:0] cnt_reg, cnt_next;
  logic              last_step;
  logic              done_next;
  logic              busy_next;
  logic [NOTE_W-1:0] note_next;

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    step_inc   = step_reg + 1'b1;
    last_step  = (step_reg == STEP_W'(SEQ_LEN - 1)) || end_tab[step_inc];

    case (state_reg)
      ST_PLAY: begin
        if (cnt_reg == play_last[step_reg]) begin
          state_next = ST_GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next = '0;
          // A finished melody always parks at step 0 so a new play starts clean.
          if (last_step) begin
            step_next = '0;
            if (LOOP != 0) begin
              state_next = ST_PLAY;
            end else begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end
          end else begin
            step_next  = step_inc;
            state_next = ST_PLAY;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: ;
    endcase

    if (stop_evt) begin
      state_next = ST_IDLE;
      step_next  = '0;
      cnt_next   = '0;
      done_next  = 1'b0;
    end else if (play_evt) begin
      step_next = '0;
      cnt_next  = '0;
      if (end_tab[0]) begin
        state_next = ST_IDLE;
        done_next  = 1'b1;
      end else begin
        state_next = ST_PLAY;
        done_next  = 1'b0;
      end
    end

    note_next = (state_next == ST_PLAY) ? note_tab[step_next] : '0;
    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      step_reg  <= '0;
      cnt_reg   <= '0;
      note_code <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      cnt_reg   <= cnt_next;
      note_code <= note_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  assign step_idx = step_reg;

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Upstream stage of the musicbox tone generator: debounces two active-low pushbuttons (play, stop) and steps through a fixed melody table, driving a note code that the tone generator turns into a square wave. Each table step holds a note for a programmable number of beats, followed by a short silent gap so repeated notes articulate. Runs on the 50 MHz board clock; the tone generator consumes `note_code` directly (0 = silence).

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles before a debounced level changes (20 ms at 50 MHz).
- `BEAT_CYCLES`, 12_500_000: cycles per beat (250 ms).
- `GAP_CYCLES`, 1_250_000: silent cycles after every note (25 ms).
- `LOOP`, 0: 1 = restart at step 0 after the end marker instead of stopping.
- `clk` in 1: 50 MHz system clock.
- `rst` in 1: synchronous, active-high reset.
- `btn_play_n` in 1: raw play button, active-low, asynchronous to `clk`.
- `btn_stop_n` in 1: raw stop button, active-low, asynchronous to `clk`.
- `note_code` out 4: note to sound, 0 = silence, 1–9 = digit-coded pitch understood by the tone generator.
- `busy` out 1: high in PLAY and GAP.
- `step_idx` out 3: current table step.
- `done` out 1: one-cycle pulse on natural end of melody.

## Operation
- Each button: 2-FF synchronizer, then debounce counter; the debounced level flips only after the synchronized input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any agreeing sample clears the counter. The press event is a one-cycle pulse in the cycle the debounced level goes to pressed (0); release produces no event.
- Table: 8 entries of {note[3:0], dur[2:0]}. `dur` = 0 is the end marker; a note of 0 with nonzero `dur` is a timed rest.
- States: IDLE, PLAY, GAP.
  - IDLE: `note_code`=0, `busy`=0. Play event -> PLAY at step 0.
  - PLAY: `note_code`=table note; stays `dur*BEAT_CYCLES` cycles -> GAP.
  - GAP: `note_code`=0; stays `GAP_CYCLES` cycles, then advances the step. If the next entry is the end marker or the step wraps past 7: with `LOOP`=0 -> IDLE and pulse `done`; with `LOOP`=1 -> PLAY at step 0, no `done`.
  - An end marker at step 0 -> play event leaves the block in IDLE and pulses `done`.
- Stop event in any state -> IDLE next cycle, step 0, no `done`.
- Play event while busy -> restart at step 0 in PLAY (duration counter cleared).
- Play and stop events in the same cycle: stop wins.
- Duration counter is 27 bits wide; it must not overflow for `dur`=7 at default `BEAT_CYCLES`.

## Timing
- Reset values: `note_code`=0, `busy`=0, `step_idx`=0, `done`=0, state IDLE, debounced levels = released (1), all counters 0. Reset mid-melody silences the output on the next edge.
- All outputs registered. Press event in cycle N -> `note_code`/`busy` valid in cycle N+1.
- Raw-button-to-event latency: 2 sync cycles + `DEBOUNCE_CYCLES` + 1.
- A step with `dur`=d occupies exactly d·`BEAT_CYCLES` + `GAP_CYCLES` cycles. The `done` pulse coincides with the first IDLE cycle.

## Structure
- Package `melody_pkg`: `NOTE_W`=4, `DUR_W`=3, `SEQ_LEN`=8, state encoding, melody table constant. The default table is 1/d2, 9/d2, 7/d4, end, then end markers in steps 4–7.
- Sub-module `btn_debounce` (synchronizer + counter + press pulse), instantiated for play and stop.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `BEAT_CYCLES`=4, `GAP_CYCLES`=2.
- Bounce: play pin toggles every 2 cycles for 20 cycles, then holds low -> exactly one press event, 2+4+1 cycles after the final edge.
- Full melody: play event -> `note_code` is 1 for 8 cycles, 0 for 2, 9 for 8, 0 for 2, 7 for 16, 0 for 2; then `done` pulses once and `busy`=0.
- Stop during step 1 (`note_code`=9) -> next cycle `note_code`=0, `busy`=0, `step_idx`=0, no `done`.
- Simultaneous play and stop events while playing -> IDLE; play alone while on step 2 -> `note_code`=1 next cycle, `step_idx`=0.
- `LOOP`=1: after step 2's gap -> `note_code`=1 immediately, `done` never asserts.
- `rst` asserted mid-note -> all outputs at reset values on the next edge; a play press after reset starts at step 0.
